// File: rtl/maxpool_window_reader_pkg.sv
// Shared constants, FSM encoding and read-tag type for the layer-1 2x2 max-pool reader.
// Memory-interface widths here match the layer-0 convolution writer.
package maxpool_window_reader_pkg;

  localparam int CNN_DATA_W    = 20;
  localparam int CNN_IMG_W     = 64;
  localparam int CNN_POOL_W    = CNN_IMG_W / 2;
  localparam int CNN_ADDR_W    = $clog2(CNN_IMG_W * CNN_IMG_W);
  localparam int CNN_WR_ADDR_W = CNN_ADDR_W - 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_LAST,
    ST_WR,
    ST_DONE
  } pool_state_e;

  // Travels one cycle behind rd_en so the returning datum knows its role.
  typedef struct packed {
    logic vld;
    logic first;
  } rd_tag_t;

  // Counter width that stays legal when the pooled image is a single window.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/maxpool_window_reader_addr_gen.sv
// Window row/column counters and in-window read index for the 2x2 pool reader;
// turns them into layer-0 read and layer-1 write addresses.
module pool_addr_gen
  import maxpool_window_reader_pkg::*;
#(
  parameter  int IMG_W  = CNN_IMG_W,
  parameter  int ADDR_W = CNN_ADDR_W,
  localparam int WA_W   = (ADDR_W > 2) ? ADDR_W - 2 : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              rd_step,
  input  logic              win_step,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [WA_W-1:0]   wr_addr,
  output logic              idx_first,
  output logic              idx_last,
  output logic              last_window
);

  localparam int POOL_W = IMG_W / 2;
  localparam int CW     = clog2_min1(POOL_W);

  logic [CW-1:0] row_q, col_q;
  logic [1:0]    idx_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      row_q <= '0;
      col_q <= '0;
      idx_q <= '0;
    end else begin
      if (rd_step) idx_q <= idx_q + 2'd1;
      if (win_step) begin
        if (col_q == CW'(POOL_W - 1)) begin
          col_q <= '0;
          row_q <= (row_q == CW'(POOL_W - 1)) ? '0 : row_q + CW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  // idx[1] selects the lower row of the window, idx[0] the right column.
  always_comb begin
    rd_addr     = ADDR_W'((2 * int'(row_q) + int'(idx_q[1])) * IMG_W
                          + 2 * int'(col_q) + int'(idx_q[0]));
    wr_addr     = WA_W'(int'(row_q) * POOL_W + int'(col_q));
    idx_first   = (idx_q == 2'd0);
    idx_last    = (idx_q == 2'd3);
    last_window = (row_q == CW'(POOL_W - 1)) && (col_q == CW'(POOL_W - 1));
  end

endmodule

// File: rtl/maxpool_window_reader.sv
// Sequential 2x2 max-pool: reads each window of layer-0 memory through one
// signed comparator and writes one pooled value per window to layer-1 memory.
module maxpool_window_reader
  import maxpool_window_reader_pkg::*;
#(
  parameter  int DATA_WIDTH = CNN_DATA_W,
  parameter  int IMG_W      = CNN_IMG_W,
  parameter  int ADDR_W     = CNN_ADDR_W,
  localparam int WA_W       = (ADDR_W > 2) ? ADDR_W - 2 : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [ADDR_W-1:0]            rd_addr,
  input  logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         wr_en,
  output logic [WA_W-1:0]              wr_addr,
  output logic signed [DATA_WIDTH-1:0] wr_data
);

  pool_state_e                  state_q, state_d;
  rd_tag_t                      rd_tag_q;
  logic signed [DATA_WIDTH-1:0] max_q;
  logic                         idx_first, idx_last, last_window;

  pool_addr_gen #(
    .IMG_W (IMG_W),
    .ADDR_W(ADDR_W)
  ) u_addr (
    .clk        (clk),
    .reset      (reset),
    .clr        ((state_q == ST_IDLE) && start),
    .rd_step    (rd_en),
    .win_step   (wr_en),
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr),
    .idx_first  (idx_first),
    .idx_last   (idx_last),
    .last_window(last_window)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_RD;
      end
      ST_RD: begin
        rd_en = 1'b1;
        if (idx_last) state_d = ST_LAST;
      end
      ST_LAST: state_d = ST_WR;
      ST_WR: begin
        wr_en   = 1'b1;
        state_d = last_window ? ST_DONE : ST_RD;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // First datum of a window loads unconditionally; later ones only if strictly
  // greater. Clearing the tag on reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_tag_q <= '0;
      max_q    <= '0;
    end else begin
      rd_tag_q <= '{vld: rd_en, first: idx_first};
      if (rd_tag_q.vld && (rd_tag_q.first || rd_data > max_q)) max_q <= rd_data;
    end
  end

  assign wr_data = max_q;

endmodule

// File: tb/tb_maxpool_window_reader.sv
// Directed bench: a 2x2-image instance for per-window value checks and a
// 64x64 instance for full-image ordering, timing and mid-run reset.
module tb_maxpool_window_reader;

  localparam int DW = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // IMG_W = 2 instance
  logic                 start2 = 1'b0;
  logic                 busy2, done2, rd_en2, wr_en2;
  logic [1:0]           rd_addr2;
  logic [0:0]           wr_addr2;
  logic signed [DW-1:0] rd_data2 = '0, wr_data2;
  logic signed [DW-1:0] mem2 [4];

  // IMG_W = 64 instance
  logic                 start64 = 1'b0;
  logic                 busy64, done64, rd_en64, wr_en64;
  logic [11:0]          rd_addr64;
  logic [9:0]           wr_addr64;
  logic signed [DW-1:0] rd_data64 = '0, wr_data64;

  maxpool_window_reader #(.DATA_WIDTH(DW), .IMG_W(2), .ADDR_W(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2)
  );

  maxpool_window_reader #(.DATA_WIDTH(DW), .IMG_W(64), .ADDR_W(12)) u64 (
    .clk(clk), .reset(reset), .start(start64), .busy(busy64), .done(done64),
    .rd_en(rd_en64), .rd_addr(rd_addr64), .rd_data(rd_data64),
    .wr_en(wr_en64), .wr_addr(wr_addr64), .wr_data(wr_data64)
  );

  // Layer-0 memories: one-cycle read latency. The 64x64 image is a ramp a-2048.
  always @(posedge clk) begin
    if (rd_en2)  rd_data2  <= mem2[rd_addr2];
    if (rd_en64) rd_data64 <= DW'(int'(rd_addr64) - 2048);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One whole-image run on the 2x2 instance; optionally pokes start while busy
  // and in the DONE cycle, both of which must be ignored.
  task automatic run2(input string tag, input int a, input int b, input int c,
                      input int d, input int expv, input bit busy_poke,
                      input bit done_poke);
    int s, nrd, nwr, bad_rd, lat, first_rd, extra;
    longint wd, wa;
    mem2[0] = DW'(a); mem2[1] = DW'(b); mem2[2] = DW'(c); mem2[3] = DW'(d);
    nrd = 0; nwr = 0; bad_rd = 0; lat = -1; first_rd = -1; extra = 0;
    wd = 0; wa = -1;
    @(negedge clk);
    start2 = 1'b1;
    s = cyc;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (rd_en2) begin
        if (first_rd < 0) first_rd = cyc - s;
        if (int'(rd_addr2) != nrd) bad_rd++;
        nrd++;
      end
      if (wr_en2) begin
        nwr++;
        wd = longint'(wr_data2);
        wa = longint'(wr_addr2);
      end
      if (busy_poke && i == 2) start2 = 1'b1;
      if (done2) begin
        lat = cyc - s;
        if (done_poke) start2 = 1'b1;
      end
    end
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rd_en2 || wr_en2 || busy2) extra++;
      @(negedge clk);
    end
    chk({tag, " data"}, wd, expv);
    chk({tag, " wr_addr"}, wa, 0);
    chk({tag, " writes"}, nwr, 1);
    chk({tag, " reads"}, nrd, 4);
    chk({tag, " rd order"}, bad_rd, 0);
    chk({tag, " first rd"}, first_rd, 1);
    chk({tag, " done lat"}, lat, 7);
    chk({tag, " idle after"}, extra, 0);
  endtask

  task automatic run64_full();
    int s, nrd, nwr, bad_rd, bad_wr, last_wr, done_at, w, k, r, c, ea;
    nrd = 0; nwr = 0; bad_rd = 0; bad_wr = 0; last_wr = -1; done_at = -1;
    @(negedge clk);
    start64 = 1'b1;
    s = cyc;
    for (int i = 0; i < 7000 && done_at < 0; i++) begin
      @(negedge clk);
      start64 = 1'b0;
      if (rd_en64) begin
        w = nrd / 4; k = nrd % 4; r = w / 32; c = w % 32;
        ea = (2 * r + k / 2) * 64 + 2 * c + k % 2;
        if (int'(rd_addr64) != ea) bad_rd++;
        nrd++;
      end
      if (wr_en64) begin
        r = nwr / 32; c = nwr % 32;
        if (int'(wr_addr64) != nwr) bad_wr++;
        if (longint'(wr_data64) != longint'((2 * r + 1) * 64 + 2 * c + 1 - 2048)) bad_wr++;
        nwr++;
        last_wr = cyc - s;
      end
      if (done64) done_at = cyc - s;
    end
    chk("full reads", nrd, 4096);
    chk("full rd_addr order", bad_rd, 0);
    chk("full writes", nwr, 1024);
    chk("full wr addr/data", bad_wr, 0);
    chk("full last WR cycle", last_wr, 6144);
    chk("full done cycle", done_at, 6145);
    @(negedge clk);
    chk("full idle after done", busy64, 0);
  endtask

  initial begin
    int found, extra, first_rd, s, got_wr;
    longint wd, wa, ra;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst busy", busy64, 0);
    chk("rst done", done64, 0);
    chk("rst rd_en", rd_en64, 0);
    chk("rst wr_en", wr_en64, 0);
    chk("rst rd_addr", rd_addr64, 0);
    chk("rst wr_addr", wr_addr64, 0);
    chk("rst wr_data", wr_data64, 0);
    chk("rst busy2", busy2, 0);

    run2("w basic", 5, -3, 12, 7, 12, 1'b0, 1'b0);
    run2("w neg ties", -8, -2, -20, -2, -2, 1'b0, 1'b0);
    run2("w max slot0", -1, -5, -6, -7, -1, 1'b0, 1'b0);
    run2("w max slot1", -50, 100, -3, 99, 100, 1'b0, 1'b0);
    run2("w max slot2", 3, 2, 524287, -524288, 524287, 1'b0, 1'b0);
    run2("w max slot3", -524288, -10, -20, 0, 0, 1'b0, 1'b0);
    run2("w start pokes", 4, 9, -1, 8, 9, 1'b1, 1'b1);
    run2("w clean rerun", 1, 2, 3, 4, 4, 1'b0, 1'b0);

    run64_full();

    // Reset during the WR cycle of window 10
    @(negedge clk);
    start64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      if (wr_en64 && wr_addr64 == 10'd10) found = 1;
      else @(negedge clk);
    end
    chk("mid rst reached window 10", found, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid rst busy", busy64, 0);
    chk("mid rst done", done64, 0);
    chk("mid rst rd_en", rd_en64, 0);
    chk("mid rst wr_en", wr_en64, 0);
    chk("mid rst rd_addr", rd_addr64, 0);
    chk("mid rst wr_addr", wr_addr64, 0);
    chk("mid rst wr_data", wr_data64, 0);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rd_en64 || wr_en64 || busy64) extra++;
    end
    chk("mid rst stays idle", extra, 0);

    // Restart must begin again at window 0
    start64 = 1'b1;
    s = cyc;
    first_rd = -1; got_wr = 0; ra = -1; wd = 0; wa = -1;
    for (int i = 0; i < 20 && got_wr == 0; i++) begin
      @(negedge clk);
      start64 = 1'b0;
      if (rd_en64 && first_rd < 0) begin
        first_rd = cyc - s;
        ra = longint'(rd_addr64);
      end
      if (wr_en64) begin
        got_wr = 1;
        wd = longint'(wr_data64);
        wa = longint'(wr_addr64);
      end
    end
    chk("restart first rd cycle", first_rd, 1);
    chk("restart first rd_addr", ra, 0);
    chk("restart wr_addr", wa, 0);
    chk("restart wr_data", wd, 65 - 2048);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
